subbytes_hamming_corrector: RTL and testbench

- Receiver end of the Hamming-protected SubBytes path.
- Accepts 12-bit codewords {sbox_data[7:0], check[3:0]} produced by the S-box/check-bit predictor, computes the 4-bit syndrome and corrects any single-bit error.
- Flags syndromes that match no column as uncorrectable.
- Two-stage valid/ready pipeline with saturating error counters; sits between the SubBytes stage and the ShiftRows stage.

---
 rtl/subbytes_hamming_corrector.sv | 176 +++++++++++++++++
 tb/tb_subbytes_hamming_corrector.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subbytes_hamming_corrector.sv
// Receiver side of the Hamming-protected SubBytes path.
// Takes a 12-bit codeword {data[7:0], check[3:0]}, computes its 4-bit syndrome,
// corrects any single-bit error and flags syndromes that match no column.
// The result goes through a two-stage valid/ready pipeline, and two saturating
// counters track corrected and uncorrectable deliveries.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready is combinational)
//   in_cw             codeword, [11:4] data, [3:0] check bits
//   out_valid/ready   downstream handshake
//   out_data          corrected data byte
//   out_status        00 clean, 01 data bit fixed, 10 check bit fixed, 11 uncorrectable
//   out_syndrome      raw syndrome of the delivered word
//   cnt_clr           synchronous clear of both counters
//   corr_cnt          delivered words with status 01 or 10 (saturating)
//   uncorr_cnt        delivered words with status 11 (saturating)
module subbytes_hamming_corrector #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [1:0]       out_status,
    output logic [3:0]       out_syndrome,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_DATA   = 2'b01;
    localparam logic [1:0] ST_CHECK  = 2'b10;
    localparam logic [1:0] ST_UNCORR = 2'b11;

    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       s1_data_q, s1_data_d;
    logic [3:0]       s1_syn_q, s1_syn_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [1:0]       out_status_q, out_status_d;
    logic [3:0]       out_syndrome_q, out_syndrome_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic       s2_free;
    logic       accept;
    logic       deliver;
    logic       corr_evt;
    logic       uncorr_evt;
    logic [3:0] in_syn;
    logic [7:0] fix_mask;
    logic [1:0] fix_status;

    // Handshake: stage 2 can take a word when empty or draining this cycle.
    assign s2_free = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid_q && out_ready;

    // Syndrome of the incoming codeword.
    always_comb begin
        in_syn[0] = ^{in_cw[11], in_cw[10], in_cw[8], in_cw[7], in_cw[6], in_cw[3]};
        in_syn[1] = ^{in_cw[11], in_cw[10], in_cw[9], in_cw[8], in_cw[6], in_cw[4], in_cw[2]};
        in_syn[2] = ^{in_cw[11], in_cw[10], in_cw[9], in_cw[7], in_cw[5], in_cw[4], in_cw[1]};
        in_syn[3] = ^{in_cw[11], in_cw[9], in_cw[8], in_cw[7], in_cw[5], in_cw[0]};
    end

    // Column lookup: data columns map to a flip of the matching data bit
    // (codeword bit k -> data bit k-4); check columns need no data change.
    always_comb begin
        fix_mask   = 8'h00;
        fix_status = ST_UNCORR;
        case (s1_syn_q)
            4'b0000: fix_status = ST_CLEAN;
            4'b1111: begin fix_mask = 8'b1000_0000; fix_status = ST_DATA; end
            4'b0111: begin fix_mask = 8'b0100_0000; fix_status = ST_DATA; end
            4'b1110: begin fix_mask = 8'b0010_0000; fix_status = ST_DATA; end
            4'b1011: begin fix_mask = 8'b0001_0000; fix_status = ST_DATA; end
            4'b1101: begin fix_mask = 8'b0000_1000; fix_status = ST_DATA; end
            4'b0011: begin fix_mask = 8'b0000_0100; fix_status = ST_DATA; end
            4'b1100: begin fix_mask = 8'b0000_0010; fix_status = ST_DATA; end
            4'b0110: begin fix_mask = 8'b0000_0001; fix_status = ST_DATA; end
            4'b0001,
            4'b0010,
            4'b0100,
            4'b1000: fix_status = ST_CHECK;
            default: fix_status = ST_UNCORR;
        endcase
    end

    // Pipeline next state: each stage holds unless it loads or drains.
    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_data_d      = s1_data_q;
        s1_syn_d       = s1_syn_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_status_d   = out_status_q;
        out_syndrome_d = out_syndrome_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_cw[11:4];
            s1_syn_d   = in_syn;
        end else if (s2_free) begin
            s1_valid_d = 1'b0;
        end

        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d     = s1_data_q ^ fix_mask;
                out_status_d   = fix_status;
                out_syndrome_d = s1_syn_q;
            end
        end
    end

    assign corr_evt   = deliver && ((out_status_q == ST_DATA) || (out_status_q == ST_CHECK));
    assign uncorr_evt = deliver && (out_status_q == ST_UNCORR);

    // Saturating counters; a clear coinciding with an event leaves a count of one.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = CNT_W'(corr_evt);
            uncorr_cnt_d = CNT_W'(uncorr_evt);
        end else begin
            if (corr_evt && (corr_cnt_q != {CNT_W{1'b1}})) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (uncorr_evt && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_data_q      <= 8'h00;
            s1_syn_q       <= 4'h0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 8'h00;
            out_status_q   <= ST_CLEAN;
            out_syndrome_q <= 4'h0;
            corr_cnt_q     <= '0;
            uncorr_cnt_q   <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_data_q      <= s1_data_d;
            s1_syn_q       <= s1_syn_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_status_q   <= out_status_d;
            out_syndrome_q <= out_syndrome_d;
            corr_cnt_q     <= corr_cnt_d;
            uncorr_cnt_q   <= uncorr_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_status   = out_status_q;
    assign out_syndrome = out_syndrome_q;
    assign corr_cnt     = corr_cnt_q;
    assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_subbytes_hamming_corrector.sv
// Bench for subbytes_hamming_corrector: directed vectors, backpressure,
// back-to-back streaming, counter saturation/clear, mid-stream reset and a
// randomized run against a column-table reference model. A second instance
// with 4-bit counters shares all inputs so saturation is reachable quickly.
module tb_subbytes_hamming_corrector;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SAT_W = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] status;
        logic [3:0] syn;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic cnt_clr = 1'b0;
    logic [11:0] in_cw = 12'h000;

    logic             in_ready, out_valid;
    logic [7:0]       out_data;
    logic [1:0]       out_status;
    logic [3:0]       out_syndrome;
    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

    logic             in_ready_s, out_valid_s;
    logic [7:0]       out_data_s;
    logic [1:0]       out_status_s;
    logic [3:0]       out_syndrome_s;
    logic [SAT_W-1:0] corr_cnt_s, uncorr_cnt_s;

    subbytes_hamming_corrector #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_status(out_status), .out_syndrome(out_syndrome), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    subbytes_hamming_corrector #(.CNT_W(SAT_W)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_cw(in_cw),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_status(out_status_s), .out_syndrome(out_syndrome_s), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt_s), .uncorr_cnt(uncorr_cnt_s)
    );

    always #5 clk = ~clk;

    // H-matrix columns indexed by codeword bit position.
    logic [3:0] col_tab [0:11];

    res_t exp_q[$];
    res_t exp_d_q[$];
    res_t got_q[$];
    int corr_m = 0;
    int uncorr_m = 0;
    int spurious = 0;
    int n_checks = 0;
    int n_fail = 0;

    function automatic res_t model(input logic [11:0] cw);
        res_t r;
        logic [3:0] syn;
        logic [7:0] d;
        syn = 4'h0;
        for (int i = 0; i < 12; i++) if (cw[i]) syn = syn ^ col_tab[i];
        d = cw[11:4];
        r.status = (syn == 4'h0) ? 2'b00 : 2'b11;
        for (int i = 0; i < 12; i++) begin
            if (syn != 4'h0 && col_tab[i] == syn) begin
                if (i >= 4) begin
                    d[i-4] = ~d[i-4];
                    r.status = 2'b01;
                end else begin
                    r.status = 2'b10;
                end
            end
        end
        r.data = d;
        r.syn  = syn;
        return r;
    endfunction

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic logic [11:0] clean_cw(input logic [7:0] d);
        logic [11:0] cw;
        res_t r;
        cw = {d, 4'h0};
        for (int c = 0; c < 16; c++) begin
            cw[3:0] = 4'(c);
            r = model(cw);
            if (r.syn == 4'h0) break;
        end
        return cw;
    endfunction

    // Advance one clock: sample handshakes before the edge, update the model after.
    task automatic tick(output logic acc_o);
        res_t a;
        logic dlv, c_rst, c_clr, ci, ui;
        logic [11:0] c_cw;
        #1;
        acc_o = in_valid && in_ready;
        dlv   = out_valid && out_ready;
        a.data = out_data; a.status = out_status; a.syn = out_syndrome;
        c_rst = rst; c_clr = cnt_clr; c_cw = in_cw;
        @(posedge clk);
        @(negedge clk);
        if (c_rst) begin
            exp_q.delete();
            corr_m = 0;
            uncorr_m = 0;
            acc_o = 1'b0;
        end else begin
            ci = dlv && (a.status == 2'b01 || a.status == 2'b10);
            ui = dlv && (a.status == 2'b11);
            if (dlv) begin
                if (exp_q.size() > 0) begin
                    exp_d_q.push_back(exp_q.pop_front());
                    got_q.push_back(a);
                end else begin
                    spurious++;
                end
            end
            corr_m   = c_clr ? int'(ci) : corr_m + int'(ci);
            uncorr_m = c_clr ? int'(ui) : uncorr_m + int'(ui);
            if (acc_o) exp_q.push_back(model(c_cw));
        end
    endtask

    task automatic test_reset();
        logic acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        tick(acc);
        tick(acc);
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_checks++; if (out_status !== 2'b00) begin n_fail++; $display("FAIL reset_out_status: got %b expected 00", out_status); end
        n_checks++; if (out_syndrome !== 4'h0) begin n_fail++; $display("FAIL reset_syndrome: got %h expected 0", out_syndrome); end
        n_checks++; if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_counters: got %h/%h expected 0/0", corr_cnt, uncorr_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        logic acc;
        logic [11:0] cw_t [4];
        logic [7:0]  d_t  [4];
        logic [1:0]  st_t [4];
        logic [3:0]  sy_t [4];
        int          c_t  [4];
        int          u_t  [4];
        cw_t = '{12'h63C, 12'h62C, 12'h634, 12'h43E};
        d_t  = '{8'h63, 8'h63, 8'h63, 8'h43};
        st_t = '{2'b00, 2'b01, 2'b10, 2'b11};
        sy_t = '{4'b0000, 4'b0110, 4'b0001, 4'b1010};
        c_t  = '{0, 1, 2, 2};
        u_t  = '{0, 0, 0, 1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_cw = cw_t[i];
            tick(acc);
            in_valid = 1'b0;
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_latency: out_valid %b expected 0 one cycle after accept", i, out_valid); end
            tick(acc);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== d_t[i] || out_status !== st_t[i] || out_syndrome !== sy_t[i]) begin
                n_fail++;
                $display("FAIL dir%0d_output: got v=%b d=%h st=%b syn=%b expected v=1 d=%h st=%b syn=%b",
                         i, out_valid, out_data, out_status, out_syndrome, d_t[i], st_t[i], sy_t[i]);
            end
            tick(acc);
            n_checks++;
            if (corr_cnt !== 16'(c_t[i]) || uncorr_cnt !== 16'(u_t[i])) begin
                n_fail++;
                $display("FAIL dir%0d_counters: got %0d/%0d expected %0d/%0d", i, corr_cnt, uncorr_cnt, c_t[i], u_t[i]);
            end
        end
        got_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [11:0] words [3];
        int w, stall_left;
        logic stalled_once;
        res_t held;
        words = '{12'h63C, 12'h62C, 12'h634};
        w = 0; stall_left = 0; stalled_once = 1'b0;
        held = '0;
        got_q.delete(); exp_d_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && got_q.size() < 3; cyc++) begin
            in_valid = (w < 3);
            in_cw    = words[(w < 3) ? w : 2];
            if (!stalled_once && out_valid) begin
                stalled_once = 1'b1;
                stall_left = 3;
                held.data = out_data; held.status = out_status; held.syn = out_syndrome;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0 while both stages full", in_ready); end
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held.data || out_status !== held.status || out_syndrome !== held.syn) begin
                    n_fail++;
                    $display("FAIL bp_hold: got v=%b d=%h st=%b syn=%h expected v=1 d=%h st=%b syn=%h",
                             out_valid, out_data, out_status, out_syndrome, held.data, held.status, held.syn);
                end
            end
            tick(acc);
            if (acc) w++;
            if (stall_left > 0) stall_left--;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d words expected 3", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_d_q[i] || got_q[i].data !== 8'h63) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h expected %h", i, got_q[i], exp_d_q[i]);
            end
        end
        got_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_back_to_back();
        logic acc;
        int n_acc;
        n_acc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_cw = clean_cw(8'($urandom)) ^ (12'h1 << $urandom_range(0, 11));
            tick(acc);
            if (acc) n_acc++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(acc);
        n_checks++; if (n_acc != 10) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 10", n_acc); end
        n_checks++; if (got_q.size() != 10) begin n_fail++; $display("FAIL b2b_delivered: got %0d expected 10", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_d_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_d_q[i]); end
        end
        got_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_saturation();
        logic acc;
        cnt_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(acc);
        cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_cw = 12'h62C;
            tick(acc);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(acc);
        n_checks++; if (corr_cnt_s !== 4'hF) begin n_fail++; $display("FAIL sat_small: got %h expected f", corr_cnt_s); end
        n_checks++; if (corr_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_wide: got %0d expected 20", corr_cnt); end
        n_checks++; if (uncorr_cnt_s !== 4'h0) begin n_fail++; $display("FAIL sat_uncorr: got %h expected 0", uncorr_cnt_s); end
        // Clear coinciding with a correctable delivery.
        in_valid = 1'b1; in_cw = 12'h62C;
        tick(acc);
        in_valid = 1'b0;
        tick(acc);
        cnt_clr = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_status !== 2'b01) begin n_fail++; $display("FAIL clr_setup: got v=%b st=%b expected v=1 st=01", out_valid, out_status); end
        tick(acc);
        cnt_clr = 1'b0;
        n_checks++; if (corr_cnt !== 16'd1 || corr_cnt_s !== 4'd1) begin n_fail++; $display("FAIL clr_same_cycle: got %0d/%0d expected 1/1", corr_cnt, corr_cnt_s); end
        n_checks++; if (uncorr_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_uncorr: got %0d expected 0", uncorr_cnt); end
        got_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_random();
        logic acc;
        logic [11:0] cw;
        int flips;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 29) == 0);
            cw = clean_cw(8'($urandom));
            flips = $urandom_range(0, 2);
            for (int f = 0; f < flips; f++) cw = cw ^ (12'h1 << $urandom_range(0, 11));
            in_cw = cw;
            tick(acc);
            n_checks++;
            if (corr_cnt !== 16'(sat(corr_m, 16)) || uncorr_cnt !== 16'(sat(uncorr_m, 16))) begin
                n_fail++;
                $display("FAIL rnd_cnt cyc%0d: got %0d/%0d expected %0d/%0d", cyc, corr_cnt, uncorr_cnt, sat(corr_m, 16), sat(uncorr_m, 16));
            end
            n_checks++;
            if (corr_cnt_s !== 4'(sat(corr_m, 4)) || uncorr_cnt_s !== 4'(sat(uncorr_m, 4))) begin
                n_fail++;
                $display("FAIL rnd_cnt_sat cyc%0d: got %0d/%0d expected %0d/%0d", cyc, corr_cnt_s, uncorr_cnt_s, sat(corr_m, 4), sat(uncorr_m, 4));
            end
        end
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(acc);
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: %0d words undelivered", exp_q.size()); end
        n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL rnd_spurious: got %0d extra deliveries expected 0", spurious); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_d_q[i]) begin n_fail++; $display("FAIL rnd_word%0d: got %h expected %h", i, got_q[i], exp_d_q[i]); end
        end
        got_q.delete(); exp_d_q.delete();
    endtask

    task automatic test_reset_mid();
        logic acc;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_cw = (i % 2 == 0) ? 12'h43E : 12'h62C;
            tick(acc);
        end
        rst = 1'b1;
        tick(acc);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        n_checks++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_cnt: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        tick(acc);
        tick(acc);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale: got out_valid %b expected 0", out_valid); end
        n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL rst_mid_spurious: got %0d expected 0", spurious); end
    endtask

    initial begin
        col_tab = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0110, 4'b1100,
                    4'b0011, 4'b1101, 4'b1011, 4'b1110, 4'b0111, 4'b1111};
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
